// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, size codes and byte-count helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} arb_state_t;

    localparam logic [1:0] SZ_1B = 2'b00;
    localparam logic [1:0] SZ_2B = 2'b01;
    localparam logic [1:0] SZ_4B = 2'b10;
    localparam logic [1:0] SZ_8B = 2'b11;

    function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/fifo_port_arbiter_rr.sv
// rr_arbiter: one-hot round-robin grant, first eligible index at or after ptr.
//   eligible : per-requester eligibility
//   ptr      : index with highest priority this cycle
//   gnt      : one-hot grant, zero when nothing is eligible
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt
);
    logic [2*NUM_REQ-1:0] dbl, dbl_gnt;
    logic [NUM_REQ-1:0]   rot, rot_gnt;

    // Rotate so ptr sits at bit 0, isolate lowest set bit, rotate back.
    always_comb begin
        dbl     = {eligible, eligible} >> ptr;
        rot     = dbl[NUM_REQ-1:0];
        rot_gnt = rot & (-rot);
        dbl_gnt = {rot_gnt, rot_gnt} << ptr;
        gnt     = dbl_gnt[2*NUM_REQ-1:NUM_REQ];
    end
endmodule

// File: rtl/fifo_port_arbiter.sv
// fifo_port_arbiter: round-robin sharing of a byte-packed FIFO write port with exact occupancy and drain.
//   clock, reset_n          : rising-edge clock, async active-low reset
//   req/req_size/req_data   : per-producer write request, size code and data
//   gnt                     : combinational one-hot grant
//   rd_ready, drain         : consumer ready, drain request
//   fifo_w_en/size/data     : registered FIFO write port
//   fifo_r_en               : registered 4-byte read strobe
//   level                   : registered byte occupancy
//   drain_done              : one-cycle pulse on drain completion
module fifo_port_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DEPTH_BYTES = 256,
    parameter int LVL_W       = 9
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [2*NUM_REQ-1:0]  req_size,
    input  logic [64*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    gnt,
    input  logic                  rd_ready,
    input  logic                  drain,
    output logic                  fifo_w_en,
    output logic [1:0]            fifo_size,
    output logic [63:0]           fifo_data,
    output logic                  fifo_r_en,
    output logic [LVL_W-1:0]      level,
    output logic                  drain_done
);
    localparam int PW  = $clog2(NUM_REQ);
    localparam int LW1 = LVL_W + 1;
    localparam logic [LVL_W:0] CAP = LW1'(DEPTH_BYTES);

    arb_state_t          state, state_nx;
    logic [PW-1:0]       ptr, win;
    logic [NUM_REQ-1:0]  eligible;
    logic [1:0]          win_size;
    logic [63:0]         win_data;
    logic                accept, rd_issue;

    // Capacity check uses the registered level only; a same-cycle read frees nothing.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = req[i] && state == RUN &&
                          ({1'b0, level} + LW1'(size_to_bytes(req_size[2*i +: 2])) <= CAP);
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .eligible (eligible),
        .ptr      (ptr),
        .gnt      (gnt)
    );

    always_comb begin
        win      = '0;
        win_size = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) begin
                win      = PW'(i);
                win_size = req_size[2*i +: 2];
                win_data = req_data[64*i +: 64];
            end
    end

    assign accept     = |gnt;
    assign rd_issue   = (state == DRAIN || rd_ready) && level >= LVL_W'(4);
    assign drain_done = state == DONE;

    // DRAIN waits for the last issued read to retire before declaring completion.
    always_comb begin
        state_nx = state;
        case (state)
            RUN:     state_nx = drain ? DRAIN : RUN;
            DRAIN:   state_nx = (level < LVL_W'(4) && !fifo_r_en) ? DONE : DRAIN;
            DONE:    state_nx = drain ? HOLD : RUN;
            default: state_nx = drain ? HOLD : RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            ptr       <= '0;
            fifo_w_en <= 1'b0;
            fifo_size <= '0;
            fifo_data <= '0;
            fifo_r_en <= 1'b0;
            level     <= '0;
        end else begin
            state     <= state_nx;
            fifo_w_en <= accept;
            fifo_r_en <= rd_issue;
            level     <= level + (accept ? LVL_W'(size_to_bytes(win_size)) : '0)
                               - (rd_issue ? LVL_W'(4) : '0);
            if (accept) begin
                fifo_size <= win_size;
                fifo_data <= win_data;
                ptr       <= (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
            end
        end
    end

    always_ff @(posedge clock)
        if (reset_n) assert ({1'b0, level} <= CAP);

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// tb_fifo_port_arbiter: directed self-checking bench for fifo_port_arbiter.
module tb_fifo_port_arbiter;
    import fifo_arb_pkg::*;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req = '0;
    logic [7:0]   req_size = '0;
    logic [255:0] req_data = '0;
    logic [3:0]   gnt;
    logic         rd_ready = 1'b0;
    logic         drain = 1'b0;
    logic         fifo_w_en;
    logic [1:0]   fifo_size;
    logic [63:0]  fifo_data;
    logic         fifo_r_en;
    logic [8:0]   level;
    logic         drain_done;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fifo_port_arbiter #(.NUM_REQ(4), .DEPTH_BYTES(256), .LVL_W(9)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .req_size   (req_size),
        .req_data   (req_data),
        .gnt        (gnt),
        .rd_ready   (rd_ready),
        .drain      (drain),
        .fifo_w_en  (fifo_w_en),
        .fifo_size  (fifo_size),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .level      (level),
        .drain_done (drain_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] dv(input int i);
        return 64'hD0D0_0000_0000_0000 + 64'(i);
    endfunction

    task automatic put(input int i, input logic on, input logic [1:0] sz);
        req[i] = on;
        req_size[2*i +: 2] = sz;
    endtask

    task automatic write0(input logic [1:0] sz, input int n);
        put(0, 1'b1, sz);
        repeat (n) tick;
        put(0, 1'b0, SZ_1B);
    endtask

    task automatic do_reset;
        req = '0;
        req_size = '0;
        rd_ready = 1'b0;
        drain = 1'b0;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req_data[64*i +: 64] = dv(i);

        // reset state
        do_reset;
        check("rst_level", level, 0);
        check("rst_w_en", fifo_w_en, 0);
        check("rst_r_en", fifo_r_en, 0);
        check("rst_size", fifo_size, 0);
        check("rst_data", fifo_data, 0);
        check("rst_done", drain_done, 0);

        // all four requesters 1B continuously: rotation 0,1,2,3,0
        for (int i = 0; i < 4; i++) put(i, 1'b1, SZ_1B);
        for (int n = 0; n < 5; n++) begin
            #1;
            check("rot_gnt", gnt, 4'b0001 << (n % 4));
            tick;
            check("rot_level", level, n + 1);
            check("rot_data", fifo_data, dv(n % 4));
        end
        req = '0;

        // single requester 4B three times
        do_reset;
        put(0, 1'b1, SZ_4B);
        for (int n = 1; n <= 3; n++) begin
            #1;
            check("w4_gnt", gnt, 4'b0001);
            tick;
            check("w4_w_en", fifo_w_en, 1);
            check("w4_size", fifo_size, SZ_4B);
            check("w4_level", level, 4 * n);
        end
        put(0, 1'b0, SZ_1B);
        tick;
        check("w4_idle_w_en", fifo_w_en, 0);
        check("w4_idle_size", fifo_size, SZ_4B);

        // near-full skip: level 252, 8B blocked, 4B granted
        do_reset;
        write0(SZ_8B, 31);
        write0(SZ_4B, 1);
        check("full_pre_level", level, 252);
        put(1, 1'b1, SZ_8B);
        put(2, 1'b1, SZ_4B);
        #1;
        check("full_skip_gnt", gnt, 4'b0100);
        tick;
        check("full_level", level, 256);
        put(2, 1'b0, SZ_1B);
        rd_ready = 1'b1;
        #1;
        check("full_block_gnt", gnt, 4'b0000);
        tick;
        check("full_r_en", fifo_r_en, 1);
        check("full_rd_level", level, 252);
        check("full_252_gnt", gnt, 4'b0000);
        tick;
        check("full_248_level", level, 248);
        check("full_248_gnt", gnt, 4'b0010);
        rd_ready = 1'b0;
        req = '0;

        // simultaneous write and read at level 6
        do_reset;
        write0(SZ_4B, 1);
        write0(SZ_2B, 1);
        check("rw_pre_level", level, 6);
        put(0, 1'b1, SZ_2B);
        rd_ready = 1'b1;
        #1;
        check("rw_gnt", gnt, 4'b0001);
        tick;
        put(0, 1'b0, SZ_1B);
        check("rw_r_en", fifo_r_en, 1);
        check("rw_w_en", fifo_w_en, 1);
        check("rw_level", level, 4);
        tick;
        check("rw2_r_en", fifo_r_en, 1);
        check("rw2_level", level, 0);
        tick;
        check("rw3_r_en", fifo_r_en, 0);
        check("rw3_level", level, 0);
        rd_ready = 1'b0;

        // drain from level 10 with pending requests
        do_reset;
        write0(SZ_8B, 1);
        write0(SZ_2B, 1);
        check("dr_pre_level", level, 10);
        drain = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) put(i, 1'b1, SZ_1B);
        #1;
        check("dr_gnt", gnt, 0);
        check("dr_r_en0", fifo_r_en, 0);
        tick;
        check("dr_r_en1", fifo_r_en, 1);
        check("dr_level1", level, 6);
        check("dr_w_en", fifo_w_en, 0);
        tick;
        check("dr_r_en2", fifo_r_en, 1);
        check("dr_level2", level, 2);
        check("dr_done_early", drain_done, 0);
        tick;
        check("dr_r_en3", fifo_r_en, 0);
        check("dr_done_wait", drain_done, 0);
        tick;
        check("dr_done", drain_done, 1);
        check("dr_done_gnt", gnt, 0);
        check("dr_done_level", level, 2);
        drain = 1'b0;
        tick;
        check("dr_done_clear", drain_done, 0);
        check("dr_resume_gnt", gnt, 4'b0010);
        req = '0;

        // asynchronous reset during an accepted write at level 100
        do_reset;
        write0(SZ_8B, 12);
        write0(SZ_4B, 1);
        check("ar_pre_level", level, 100);
        for (int i = 0; i < 4; i++) put(i, 1'b1, SZ_4B);
        #1;
        check("ar_pre_gnt", gnt, 4'b0010);
        #1;
        reset_n = 1'b0;
        #1;
        check("ar_level", level, 0);
        check("ar_w_en", fifo_w_en, 0);
        check("ar_size", fifo_size, 0);
        check("ar_data", fifo_data, 0);
        reset_n = 1'b1;
        #1;
        check("ar_first_gnt", gnt, 4'b0001);
        tick;
        check("ar_post_level", level, 4);
        check("ar_post_data", fifo_data, dv(0));
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_port_arbiter.md
Name: fifo_port_arbiter

Overview:
- Shares the write port of the byte-packed FIFO (1/2/4/8-byte writes, 4-byte reads, 256-byte store) among NUM_REQ producers using round-robin arbitration.
- Keeps an exact byte-occupancy count, so the FIFO is never written past capacity and never read with fewer than 4 bytes present.
- Schedules 4-byte reads for a single consumer.
- Provides a drain mode that blocks writes and empties whole words before a flush or reconfiguration.
- Sits between the producers/consumer and the FIFO instance.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- DEPTH_BYTES, 256, FIFO capacity in bytes (power of 2).
- LVL_W, 9, occupancy counter width; holds 0..DEPTH_BYTES.

Ports:
- clock  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester write request; held with data until granted.
- req_size  in  2*NUM_REQ  size code per requester (00=1B, 01=2B, 10=4B, 11=8B); slice i = [2i+1:2i].
- req_data  in  64*NUM_REQ  write data per requester; byte 0 is LSB.
- gnt  out  NUM_REQ  combinational one-hot; transfer occurs on an edge where req[i]&gnt[i].
- rd_ready  in  1  consumer ready to take one 4-byte word.
- drain  in  1  level request to empty the FIFO of whole words.
- fifo_w_en  out  1  to FIFO w_en; registered.
- fifo_size  out  2  to FIFO size; registered.
- fifo_data  out  64  to FIFO data_in; registered.
- fifo_r_en  out  1  to FIFO r_en; registered.
- level  out  LVL_W  current byte occupancy; registered.
- drain_done  out  1  one-cycle pulse when drain completes.

Behaviour:
- Reset values (asynchronous):
  - all outputs 0, level=0, round-robin pointer=0, state=RUN.
  - The FIFO shares reset_n. A reset mid-transfer discards the registered write/read and the occupancy.
- Byte count per write: nbytes = 1<<size (1, 2, 4 or 8).
- Eligibility: requester i is eligible when req[i] && state==RUN && level + nbytes(i) <= DEPTH_BYTES.
  - The check uses the current registered level; a read in the same cycle frees no space for this cycle (conservative).
- Arbitration:
  - Round-robin starting at pointer p.
  - gnt = the first eligible index scanning p, p+1, ... mod NUM_REQ; gnt = 0 if none is eligible.
  - After an accepted transfer from requester k, p <= (k+1) mod NUM_REQ. Otherwise p holds.
- Write issue:
  - On an accepted edge: fifo_w_en<=1, fifo_size<=req_size[k], fifo_data<=req_data[k].
  - Otherwise fifo_w_en<=0 and size/data hold.
  - One write per cycle maximum. Back-to-back grants are allowed.
- Read issue:
  - fifo_r_en <= rd_ready && level >= 4.
  - Bytes written in the same cycle are not counted toward this check.
  - The FIFO returns valid_out one cycle after fifo_r_en (consumer's concern; not tracked here).
- Level update: level <= level + (accepted ? nbytes : 0) - (read issued ? 4 : 0). Simultaneous write and read apply both terms.
  - Invariant: 0 <= level <= DEPTH_BYTES. This is an assertion, not a clamp.
  - The FIFO's own full flag is ignored; level is authoritative.
- State machine:
  - RUN: normal operation. drain=1 -> DRAIN.
  - DRAIN:
    - gnt forced 0.
    - Reads are issued whenever level >= 4, independent of rd_ready.
    - When level < 4 and no read is in flight -> DONE.
  - DONE:
    - drain_done=1 for exactly one cycle.
    - If drain=1, stay in HOLD (writes still blocked); otherwise -> RUN.
  - HOLD: drain deasserts -> RUN.
  - Residual bytes (level 1..3) remain in DONE/HOLD; level is reported unchanged.
- Size code encoding: all four codes are valid; no illegal sizes.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state enum {RUN, DRAIN, DONE, HOLD};
  - size code constants SZ_1B..SZ_8B;
  - function size_to_bytes(size) returning a 4-bit byte count.
- Sub-module rr_arbiter (NUM_REQ parameter; inputs eligible vector and pointer; output one-hot grant) is natural and reusable.
- Occupancy, FSM and issue registers stay in the top.

Test Plan:
- Single requester 0 writes size=10 three times, rd_ready=0 -> gnt[0] on each, level 4, 8, 12; fifo_w_en pulses with fifo_size=10.
- All 4 requesters hold size=00 continuously -> grants rotate 0,1,2,3,0; level increments by 1 per cycle.
- Set level=252 via writes, then requester 1 size=11 with requester 2 size=10 -> gnt skips 1 and grants 2; level=256. With rd_ready=1, next cycle r_en issues (level 252), and requester 1 remains blocked until level <= 248.
- Level=6, rd_ready=1 with simultaneous 2-byte write -> fifo_r_en=1, level=4 next cycle, then another read -> level=0.
- Level=10, drain=1 with requests pending -> gnt=0, two reads issued, level=2, drain_done pulses once; drain low -> RUN and grants resume.
- Assert reset_n low during an accepted write at level 100 -> all outputs 0, level=0 immediately; after release, the first grant goes to requester 0.
